// File: rtl/gabor_pkg.sv
// gabor_pkg: shared widths, default padded-image geometry and window type for the Gabor front end
package gabor_pkg;
  localparam int PIX_W     = 8;
  localparam int OUT_W     = 10;
  localparam int ADDR_W    = 19;
  localparam int IMG_W_DEF = 516;
  localparam int IMG_H_DEF = 516;
  typedef logic [0:4][0:4][PIX_W-1:0] win_t;
endpackage

// File: rtl/gabor_line_buffer.sv
// gabor_line_buffer: DEPTH-long delay line with enable, circular RAM with one shared read/write pointer
//   clk, rst (sync, active-low) -- rst only rewinds the pointer, RAM contents are kept
//   en   : shift one sample in and one out
//   din  : sample written at the pointer
//   dout : sample written DEPTH enables ago (read before the same-enable write)
module gabor_line_buffer
  import gabor_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEF,
  parameter int WIDTH = PIX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr_q;
  assign dout = mem[ptr_q];
  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= '0;
    else if (en) ptr_q <= ptr_q == AW'(DEPTH - 1) ? '0 : ptr_q + AW'(1);
  end
  always_ff @(posedge clk) if (en) mem[ptr_q] <= din;
endmodule

// File: rtl/gabor_window_gen_5x5.sv
// gabor_window_gen_5x5: raster pixel stream to registered 5x5 windows for conv_unit
//   clk, rst (sync, active-low)
//   in_valid/in_sof/in_pixel : raster stream, in_sof forces the pixel to (0,0)
//   pixel1..pixel25          : window row-major, pixel1 top-left, zero-extended to OUT_W
//   win_valid                : one-cycle strobe for pixel1..25 and win_addr
//   win_addr                 : padded-image address of pixel1
//   frame_done               : strobe of the last window of a frame
module gabor_window_gen_5x5 #(
  parameter int IMG_W  = gabor_pkg::IMG_W_DEF,
  parameter int IMG_H  = gabor_pkg::IMG_H_DEF,
  parameter int PIX_W  = gabor_pkg::PIX_W,
  parameter int OUT_W  = gabor_pkg::OUT_W,
  parameter int ADDR_W = gabor_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [PIX_W-1:0]  in_pixel,
  output logic [OUT_W-1:0]  pixel1,
  output logic [OUT_W-1:0]  pixel2,
  output logic [OUT_W-1:0]  pixel3,
  output logic [OUT_W-1:0]  pixel4,
  output logic [OUT_W-1:0]  pixel5,
  output logic [OUT_W-1:0]  pixel6,
  output logic [OUT_W-1:0]  pixel7,
  output logic [OUT_W-1:0]  pixel8,
  output logic [OUT_W-1:0]  pixel9,
  output logic [OUT_W-1:0]  pixel10,
  output logic [OUT_W-1:0]  pixel11,
  output logic [OUT_W-1:0]  pixel12,
  output logic [OUT_W-1:0]  pixel13,
  output logic [OUT_W-1:0]  pixel14,
  output logic [OUT_W-1:0]  pixel15,
  output logic [OUT_W-1:0]  pixel16,
  output logic [OUT_W-1:0]  pixel17,
  output logic [OUT_W-1:0]  pixel18,
  output logic [OUT_W-1:0]  pixel19,
  output logic [OUT_W-1:0]  pixel20,
  output logic [OUT_W-1:0]  pixel21,
  output logic [OUT_W-1:0]  pixel22,
  output logic [OUT_W-1:0]  pixel23,
  output logic [OUT_W-1:0]  pixel24,
  output logic [OUT_W-1:0]  pixel25,
  output logic              win_valid,
  output logic [ADDR_W-1:0] win_addr,
  output logic              frame_done
);
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam int WINS = (IMG_W - 4) * (IMG_H - 4);
  localparam int NW   = $clog2(WINS + 1);
  typedef logic [0:4][0:4][PIX_W-1:0] win_t;
  logic [CW-1:0]     col_q, col_d, cur_col;
  logic [RW-1:0]     row_q, row_d, cur_row;
  logic [NW-1:0]     cnt_q, cnt_d, cur_cnt;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, done_q, sof, col_end, fire, last;
  win_t              sh_q, sh_d, win_q;
  // chain[0] is the live pixel, chain[k] the same column k rows up
  logic [PIX_W-1:0]  chain [5];
  assign chain[0] = in_pixel;
  for (genvar i = 0; i < 4; i++) begin : g_lb
    gabor_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb (
      .clk  (clk),
      .rst  (rst),
      .en   (in_valid),
      .din  (chain[i]),
      .dout (chain[i+1])
    );
  end
  always_comb begin
    sof     = in_valid && in_sof;
    cur_col = sof ? '0 : col_q;
    cur_row = sof ? '0 : row_q;
    cur_cnt = sof ? '0 : cnt_q;
    col_end = cur_col == CW'(IMG_W - 1);
    col_d   = col_end ? '0 : cur_col + CW'(1);
    row_d   = !col_end ? cur_row : cur_row == RW'(IMG_H - 1) ? '0 : cur_row + RW'(1);
    // windows only once the bottom-right pixel has 4 full rows and 4 columns of the same row behind it
    fire    = in_valid && cur_row >= RW'(4) && cur_col >= CW'(4);
    last    = cur_cnt == NW'(WINS - 1);
    cnt_d   = !fire ? cur_cnt : last ? '0 : cur_cnt + NW'(1);
    addr_d  = ADDR_W'(cur_row - RW'(4)) * ADDR_W'(IMG_W) + ADDR_W'(cur_col - CW'(4));
    sh_d    = sh_q;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) sh_d[r][c] = sh_q[r][c+1];
      sh_d[r][4] = chain[4-r];
    end
  end
  always_ff @(posedge clk) if (in_valid) sh_q <= sh_d;
  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      win_q   <= '0;
    end else begin
      valid_q <= fire;
      done_q  <= fire && last;
      if (in_valid) begin
        col_q <= col_d;
        row_q <= row_d;
        cnt_q <= cnt_d;
      end
      if (fire) begin
        addr_q <= addr_d;
        win_q  <= sh_d;
      end
    end
  end
  assign win_valid  = valid_q;
  assign frame_done = done_q;
  assign win_addr   = addr_q;
  assign pixel1  = OUT_W'(win_q[0][0]);
  assign pixel2  = OUT_W'(win_q[0][1]);
  assign pixel3  = OUT_W'(win_q[0][2]);
  assign pixel4  = OUT_W'(win_q[0][3]);
  assign pixel5  = OUT_W'(win_q[0][4]);
  assign pixel6  = OUT_W'(win_q[1][0]);
  assign pixel7  = OUT_W'(win_q[1][1]);
  assign pixel8  = OUT_W'(win_q[1][2]);
  assign pixel9  = OUT_W'(win_q[1][3]);
  assign pixel10 = OUT_W'(win_q[1][4]);
  assign pixel11 = OUT_W'(win_q[2][0]);
  assign pixel12 = OUT_W'(win_q[2][1]);
  assign pixel13 = OUT_W'(win_q[2][2]);
  assign pixel14 = OUT_W'(win_q[2][3]);
  assign pixel15 = OUT_W'(win_q[2][4]);
  assign pixel16 = OUT_W'(win_q[3][0]);
  assign pixel17 = OUT_W'(win_q[3][1]);
  assign pixel18 = OUT_W'(win_q[3][2]);
  assign pixel19 = OUT_W'(win_q[3][3]);
  assign pixel20 = OUT_W'(win_q[3][4]);
  assign pixel21 = OUT_W'(win_q[4][0]);
  assign pixel22 = OUT_W'(win_q[4][1]);
  assign pixel23 = OUT_W'(win_q[4][2]);
  assign pixel24 = OUT_W'(win_q[4][3]);
  assign pixel25 = OUT_W'(win_q[4][4]);
endmodule

// File: tb/tb_gabor_window_gen_5x5.sv
// tb_gabor_window_gen_5x5: frame-store reference model, ramp checkpoint table and randomized streams
module tb_gabor_window_gen_5x5;
  localparam int W = 8;
  localparam int H = 7;
  logic clk = 0;
  logic rst = 0;
  logic in_valid = 0, in_sof = 0;
  logic [7:0] in_pixel = 0;
  logic [9:0] pixel1, pixel2, pixel3, pixel4, pixel5, pixel6, pixel7, pixel8, pixel9, pixel10;
  logic [9:0] pixel11, pixel12, pixel13, pixel14, pixel15, pixel16, pixel17, pixel18, pixel19, pixel20;
  logic [9:0] pixel21, pixel22, pixel23, pixel24, pixel25;
  logic win_valid, frame_done;
  logic [18:0] win_addr;
  logic [249:0] act_win;
  always #5 clk = ~clk;
  gabor_window_gen_5x5 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
    .pixel1(pixel1), .pixel2(pixel2), .pixel3(pixel3), .pixel4(pixel4), .pixel5(pixel5),
    .pixel6(pixel6), .pixel7(pixel7), .pixel8(pixel8), .pixel9(pixel9), .pixel10(pixel10),
    .pixel11(pixel11), .pixel12(pixel12), .pixel13(pixel13), .pixel14(pixel14), .pixel15(pixel15),
    .pixel16(pixel16), .pixel17(pixel17), .pixel18(pixel18), .pixel19(pixel19), .pixel20(pixel20),
    .pixel21(pixel21), .pixel22(pixel22), .pixel23(pixel23), .pixel24(pixel24), .pixel25(pixel25),
    .win_valid(win_valid), .win_addr(win_addr), .frame_done(frame_done)
  );
  assign act_win = {pixel1, pixel2, pixel3, pixel4, pixel5, pixel6, pixel7, pixel8, pixel9, pixel10,
                    pixel11, pixel12, pixel13, pixel14, pixel15, pixel16, pixel17, pixel18, pixel19, pixel20,
                    pixel21, pixel22, pixel23, pixel24, pixel25};
  int n_chk = 0, n_pass = 0;
  int nwin = 0, ndone = 0, first_p25 = -1;
  bit chk_en = 0;
  logic [7:0] img [H][W];
  int mr = 0, mc = 0;
  logic nxt_valid = 0, nxt_done = 0, e_valid = 0, e_done = 0;
  logic [18:0] nxt_addr = 0, e_addr = 0;
  logic [249:0] nxt_win = 0, e_win = 0;
  task automatic chk(input bit ok, input string nm, input logic [255:0] a, input logic [255:0] e);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, a, e);
  endtask
  // model: whole-frame store indexed by stream position; a window is the 5x5 block ending at the new pixel
  task automatic send(input bit v, input bit sof, input logic [7:0] pix);
    in_valid = v; in_sof = sof; in_pixel = pix;
    nxt_valid = 0; nxt_done = 0;
    if (v) begin
      if (sof) begin mr = 0; mc = 0; end
      img[mr][mc] = pix;
      if (mr >= 4 && mc >= 4) begin
        nxt_valid = 1;
        nxt_done = (mr == H - 1 && mc == W - 1);
        nxt_addr = 19'((mr - 4) * W + (mc - 4));
        for (int i = 0; i < 25; i++) nxt_win[(24 - i) * 10 +: 10] = {2'b00, img[mr - 4 + i / 5][mc - 4 + i % 5]};
      end
      mc++;
      if (mc == W) begin mc = 0; mr = (mr + 1) % H; end
    end
    @(negedge clk);
  endtask
  task automatic do_reset(input int n);
    rst = 0; in_valid = 0; in_sof = 0;
    nxt_valid = 0; nxt_done = 0; nxt_addr = 0; nxt_win = 0; mr = 0; mc = 0;
    repeat (n) @(negedge clk);
    rst = 1;
  endtask
  task automatic ramp_frame(input bit sof, input bit gaps);
    for (int i = 0; i < W * H; i++) begin
      while (gaps && $urandom_range(1) == 1) send(0, 0, 8'($urandom));
      send(1, sof && i == 0, 8'(i));
    end
  endtask
  always @(posedge clk) begin
    e_valid <= nxt_valid; e_done <= nxt_done; e_addr <= nxt_addr; e_win <= nxt_win;
  end
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk(win_valid == e_valid && frame_done == e_done, "strobe", {win_valid, frame_done}, {e_valid, e_done});
      chk(win_addr == e_addr, "win_addr", win_addr, e_addr);
      chk(act_win == e_win, "window", act_win, e_win);
      if (win_valid) begin
        if (nwin == 0) first_p25 = int'(pixel25);
        nwin++;
        if (frame_done) ndone++;
        chk(int'(win_addr) % W <= 3, "row_boundary", win_addr, 3);
      end
    end
  end
  typedef struct {int idx; bit v; bit d; int addr; int p1; int p5; int p21; int p25;} vec_t;
  vec_t tbl [6];
  initial begin
    tbl[0] = '{35, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{36, 1, 0, 0, 0, 4, 32, 36};
    tbl[2] = '{39, 1, 0, 3, 3, 7, 35, 39};
    tbl[3] = '{40, 0, 0, 3, 3, 7, 35, 39};
    tbl[4] = '{44, 1, 0, 8, 8, 12, 40, 44};
    tbl[5] = '{55, 1, 1, 19, 19, 23, 51, 55};
    chk_en = 1;
    do_reset(2);
    chk({win_valid, frame_done, win_addr, act_win} == '0, "reset_state", {win_valid, frame_done, win_addr, act_win}, 0);
    nwin = 0;
    for (int i = 0; i < W * H; i++) begin
      send(1, i == 0, 8'(i));
      for (int k = 0; k < 6; k++)
        if (tbl[k].idx == i)
          chk({win_valid, frame_done, win_addr, pixel1, pixel5, pixel21, pixel25} ==
              {tbl[k].v, tbl[k].d, 19'(tbl[k].addr), 10'(tbl[k].p1), 10'(tbl[k].p5), 10'(tbl[k].p21), 10'(tbl[k].p25)},
              "ramp_table", {win_valid, frame_done, win_addr, pixel1, pixel5, pixel21, pixel25},
              {tbl[k].v, tbl[k].d, 19'(tbl[k].addr), 10'(tbl[k].p1), 10'(tbl[k].p5), 10'(tbl[k].p21), 10'(tbl[k].p25)});
    end
    send(0, 0, 0);
    chk(nwin == 12, "ramp_count", nwin, 12);
    nwin = 0;
    ramp_frame(0, 1);
    send(0, 0, 0);
    chk(nwin == 12, "gap_count", nwin, 12);
    for (int i = 0; i < 20; i++) send(1, 0, 8'($urandom));
    do_reset(1);
    chk({win_valid, frame_done, win_addr, act_win} == '0, "mid_reset_state", {win_valid, frame_done, win_addr, act_win}, 0);
    nwin = 0;
    ramp_frame(1, 0);
    send(0, 0, 0);
    chk(nwin == 12, "post_reset_count", nwin, 12);
    for (int i = 0; i < 30; i++) send(1, 0, 8'($urandom));
    nwin = 0;
    ramp_frame(1, 0);
    send(0, 0, 0);
    chk(nwin == 12, "sof_restart_count", nwin, 12);
    chk(first_p25 == 36, "sof_first_p25", first_p25, 36);
    nwin = 0; ndone = 0;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < W * H; i++) begin
        while (f > 0 && $urandom_range(3) == 0) send(0, 0, 8'($urandom));
        send(1, f == 0 && i == 0, 8'($urandom));
      end
    send(0, 0, 0);
    send(1, 1, 8'hA5);
    send(0, 0, 0);
    chk(nwin == 36, "b2b_windows", nwin, 36);
    chk(ndone == 3, "b2b_frame_done", ndone, 3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
